// File: rtl/serial_tx.sv
// Framed parallel-in / serial-out transmitter.
// Sends start bit, DATA_W data bits LSB first, optional parity bit and a stop
// bit. Each bit is held for CLKS_PER_BIT clocks. All outputs are registered.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   din   - word to transmit, captured on an accepting edge
//   load  - request to transmit din
//   ready - a load is accepted on this edge
//   tx    - serial line, idles high
//   tx_n  - registered complement of tx
//   busy  - frame in progress
//   done  - one-cycle pulse after the last stop cycle
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              tx_n,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  shift_nxt;
  logic               par_q, par_d;
  logic               tx_d, ready_d, busy_d, done_d;
  logic               wrap;

  assign wrap      = (cnt_q == CNT_LAST);
  assign shift_nxt = shift_q >> 1;

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // the registered values line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;

    // Bit-period counter; only the wrap cycle advances the frame.
    if (state_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (load && ready) begin
          shift_d = din;
          par_d   = (^din) ^ 1'(PARITY_ODD);
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (wrap) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (wrap) begin
          shift_d = shift_nxt;
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_nxt[0];
          end
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (wrap) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (wrap) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_n    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
      tx_n    <= ~tx_d;
      ready   <= ready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: four instances with different
// configurations share rst/load/din and are compared every cycle against a
// frame-level reference model, plus directed checks of frame lengths and
// specific bit sequences.
module tb_serial_tx;

  localparam int N = 4;

  // Per-instance configuration: width, clocks per bit, parity enable, odd.
  int pw [N] = '{8, 8, 8, 4};
  int pc [N] = '{4, 4, 4, 1};
  int pe [N] = '{1, 1, 0, 1};
  int po [N] = '{0, 1, 0, 0};

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din  = 8'h00;

  logic ready_o [N];
  logic tx_o    [N];
  logic tx_n_o  [N];
  logic busy_o  [N];
  logic done_o  [N];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready_o[0]),
    .tx(tx_o[0]), .tx_n(tx_n_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready_o[1]),
    .tx(tx_o[1]), .tx_n(tx_n_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_c (
    .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready_o[2]),
    .tx(tx_o[2]), .tx_n(tx_n_o[2]), .busy(busy_o[2]), .done(done_o[2]));
  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_d (
    .clk(clk), .rst(rst), .din(din[3:0]), .load(load), .ready(ready_o[3]),
    .tx(tx_o[3]), .tx_n(tx_n_o[3]), .busy(busy_o[3]), .done(done_o[3]));

  // Reference model: a frame is a list of bits; while active, the line shows
  // bit (elapsed cycles / clocks per bit).
  bit          act [N];
  bit          dn  [N];
  int          tt  [N];
  int          nb  [N];
  logic [31:0] fr  [N];

  function automatic void start_frame(int i, logic [7:0] d);
    int ones;
    int n;
    ones = 0;
    fr[i] = '0;
    fr[i][0] = 1'b0;
    for (int k = 0; k < pw[i]; k++) begin
      fr[i][1 + k] = d[k];
      ones += int'(d[k]);
    end
    n = 1 + pw[i];
    if (pe[i] != 0) begin
      fr[i][n] = 1'((ones % 2) ^ po[i]);
      n++;
    end
    fr[i][n] = 1'b1;
    nb[i] = n + 1;
    tt[i] = 0;
    act[i] = 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        act[i] = 1'b0;
        dn[i]  = 1'b0;
      end else if (act[i]) begin
        tt[i]++;
        if (tt[i] == nb[i] * pc[i]) begin
          act[i] = 1'b0;
          dn[i]  = 1'b1;
        end else begin
          dn[i] = 1'b0;
        end
      end else begin
        dn[i] = 1'b0;
        if (load) start_frame(i, din);
      end
    end
  end

  function automatic int exp_tx(int i);
    return act[i] ? int'(fr[i][tt[i] / pc[i]]) : 1;
  endfunction

  task automatic check(input string tag, input int got, input int expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, expv);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("tx[%0d]", i),    int'(tx_o[i]),    exp_tx(i));
      check($sformatf("tx_n[%0d]", i),  int'(tx_n_o[i]),  1 - exp_tx(i));
      check($sformatf("busy[%0d]", i),  int'(busy_o[i]),  int'(act[i]));
      check($sformatf("ready[%0d]", i), int'(ready_o[i]), int'(!act[i]));
      check($sformatf("done[%0d]", i),  int'(done_o[i]),  int'(dn[i]));
    end
  endtask

  // Advance to the next falling edge and compare every instance.
  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      step();
      ok = 1'b1;
      for (int i = 0; i < N; i++)
        if (!ready_o[i] || done_o[i]) ok = 1'b0;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_done_a();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      seen = done_o[0];
    end
    if (!seen) check("done_a_timeout", 0, 1);
  endtask

  int         done_at [N];
  int         exp_len [N] = '{44, 44, 40, 7};
  logic [6:0] d_seq;

  initial begin
    // Reset, checked against the model's reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Frame A5 on all instances; measure START-to-done distance.
    din = 8'hA5; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < N; i++) done_at[i] = -1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      step();
      for (int i = 0; i < N; i++)
        if (done_o[i] && done_at[i] < 0) done_at[i] = cyc;
    end
    for (int i = 0; i < N; i++)
      check($sformatf("frame_len[%0d]", i), done_at[i], exp_len[i]);
    wait_idle();

    // din=01 frame, then the 4-bit single-clock sequence for 4'hB.
    din = 8'h01; load = 1'b1;
    step();
    load = 1'b0;
    wait_idle();
    din = 8'h0B; load = 1'b1;
    step();
    load = 1'b0;
    d_seq = 7'b1110110;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("d_seq[%0d]", k), int'(tx_o[3]), int'(d_seq[k]));
      step();
    end
    check("d_done_after_stop", int'(done_o[3]), 1);
    wait_idle();

    // Back-to-back: reload FF in A's done cycle.
    din = 8'h3C; load = 1'b1;
    step();
    load = 1'b0;
    wait_done_a();
    check("b2b_ready_in_done", int'(ready_o[0]), 1);
    din = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    check("b2b_start_tx", int'(tx_o[0]), 0);
    check("b2b_start_busy", int'(busy_o[0]), 1);
    wait_idle();

    // Loads during a frame are ignored; load still high at done captures 00.
    din = 8'h81; load = 1'b1;
    step();
    din = 8'h00;
    wait_done_a();
    step();
    load = 1'b0;
    check("ignored_load_recaptured", int'(busy_o[0]), 1);
    wait_idle();

    // Reset during data bit 3 of F0, then a clean frame of 55.
    din = 8'hF0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (17) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_tx", int'(tx_o[0]), 1);
    check("rst_mid_busy", int'(busy_o[0]), 0);
    check("rst_mid_ready", int'(ready_o[0]), 1);
    check("rst_mid_done", int'(done_o[0]), 0);
    din = 8'h55; load = 1'b1;
    step();
    load = 1'b0;
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      din  = 8'($urandom);
      load = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
